freq_meter: RTL and testbench
=============================

# freq_meter

Gated-window frequency counter for the demo board. It counts rising edges of an asynchronous square-wave input over a fixed window of `GATE` system-clock cycles, then latches the count as the measured frequency. It is the measurement-side counterpart of the board's decade clock divider: any divider tap can be looped into `sig_in` to confirm its rate, and the result can drive the display counters.

## Interface

Parameters:
- `N`, 30: gate-counter width; requires `GATE-1 < 2^N`.
- `GATE`, 50000000: window length in `clk` cycles (1 s at 50 MHz); minimum 2.
- `W`, 16: width of the edge counter and result.

Ports (name, direction, width, meaning):
- `clk` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `en` in 1: measurement enable, synchronous.
- `sig_in` in 1: asynchronous square wave under test.
- `count` out W: latched edge count from the last completed window.
- `valid` out 1: one-cycle pulse when `count` updates.
- `ovf` out 1: the last completed window saturated.
- `busy` out 1: a window is in progress.

## Operation

- Input path:
  - `sig_in` passes through a 2-flop synchronizer (`s1`, `s2`) plus a history flop `s3`.
  - `edge = s2 & ~s3`.
  - This path runs whenever `reset` is high, independent of `en`.
- FSM states: IDLE, MEASURE, LATCH.
  - IDLE: `gate_cnt=0`, `edge_cnt=0`, `busy=0`. Goes to MEASURE on the first cycle `en=1`.
  - MEASURE: `busy=1`.
    - `gate_cnt` increments each cycle from 0.
    - `edge_cnt` increments on each cycle `edge=1`.
    - When `gate_cnt==GATE-1`, go to LATCH. The edge in that terminal cycle is included.
    - If `en=0` in any MEASURE cycle, go to IDLE and discard the partial count. `count`, `ovf` and `valid` are unchanged.
  - LATCH (one cycle):
    - Outputs: `count<=edge_cnt`, `ovf<=sat`, `valid<=1`.
    - Counters clear. Next state is MEASURE if `en=1`, else IDLE.
    - An edge occurring in the LATCH cycle is not counted.
    - The next window therefore starts one cycle later. Its span is measured from MEASURE entry.
- Arithmetic and saturation:
  - `edge_cnt` saturates at 2^W-1 and does not wrap.
  - Internal flag `sat` sets when an edge arrives while `edge_cnt==2^W-1`, and clears with the counters.
- `count` and `ovf` hold their values until the next LATCH.
- Reset (`reset=0`, any time, including mid-window):
  - All flops clear immediately; FSM goes to IDLE.
  - `count=0`, `ovf=0`, `valid=0`, `busy=0`, synchronizer flops 0.
- Measured frequency = `count`·f_clk/`GATE`. The input must be slower than f_clk/2 to be counted exactly.

## Timing

- A `sig_in` rising edge meeting setup at clock edge t makes `edge=1` during the cycle after edge t+1. `edge_cnt` increments at edge t+2.
- `en` rising, sampled at edge t, enters MEASURE at t. The first MEASURE cycle has `gate_cnt=0`, and the gate spans exactly `GATE` cycles.
- LATCH occupies the cycle after the terminal MEASURE cycle:
  - `valid` is high for exactly the one cycle following LATCH.
  - `count`/`ovf` change at the same edge that raises `valid`.
- Back-to-back windows with `en` held high: `valid` period is `GATE+1` cycles.
- `busy` is registered and equals (state==MEASURE).
- After `reset` deasserts, the first window can complete no earlier than `GATE+1` cycles after `en` is sampled high.

## Test plan

- Steady rate: `GATE=100`, `en=1`, `sig_in` period 10 clk, phase-aligned so no edge falls in the LATCH cycle → each window `count=10`, `ovf=0`, `valid` every 101 cycles.
- DC input: `sig_in` held at 1 (then at 0), `GATE=100` → `count=0` on every `valid`.
- Saturation: `W=4`, `GATE=100`, `sig_in` period 4 (25 edges) → `count=15`, `ovf=1`. Then period 20 → next window `count=5`, `ovf=0`.
- Abort: `en` dropped at `gate_cnt=50` → no `valid`, `busy` falls next cycle, previous `count` retained. Re-asserting `en` starts a fresh window of full length.
- Reset mid-window: `reset=0` at `gate_cnt=70` with `count=10` latched → immediately `count=0`, `busy=0`, `valid=0`. After release with `en=1`, the first `valid` comes 101 cycles later.
- Edge at boundary: single `sig_in` rise placed so `edge=1` in the terminal MEASURE cycle → counted (`count=1`). Placed so `edge=1` in the LATCH cycle → counted in neither window.

Source files
------------

// File: rtl/freq_meter.sv
// -----------------------------------------------------------------------------
// freq_meter
// Gated-window frequency counter. Rising edges of an asynchronous square wave
// are counted over a window of GATE clk cycles; at the end of each window the
// count is latched and announced with a one-cycle valid pulse.
//
// Parameters:
//   N    - gate-counter width (GATE-1 must fit in N bits)
//   GATE - window length in clk cycles (>= 2)
//   W    - edge counter / result width
//
// Ports:
//   clk    in  1  system clock, rising edge
//   reset  in  1  asynchronous active-low reset
//   en     in  1  measurement enable (synchronous)
//   sig_in in  1  asynchronous signal under test
//   count  out W  edge count of the last completed window
//   valid  out 1  one-cycle pulse when count/ovf update
//   ovf    out 1  last completed window saturated
//   busy   out 1  a window is in progress (state == MEASURE)
// -----------------------------------------------------------------------------
module freq_meter #(
   parameter int N    = 30,
   parameter int GATE = 50000000,
   parameter int W    = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         sig_in,
   output logic [W-1:0] count,
   output logic         valid,
   output logic         ovf,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      LATCH   = 2'd2
   } state_t;

   localparam logic [N-1:0] GATE_LAST = N'(GATE - 1);
   localparam logic [W-1:0] CNT_MAX   = {W{1'b1}};

   state_t         r_state;
   state_t         w_next;

   logic           r_s1;
   logic           r_s2;
   logic           r_s3;
   logic           w_edge;
   logic           w_term;

   logic [N-1:0]   r_gate_cnt;
   logic [W-1:0]   r_edge_cnt;
   logic           r_sat;

   logic [W-1:0]   r_count;
   logic           r_valid;
   logic           r_ovf;
   logic           r_busy;

   assign count  = r_count;
   assign valid  = r_valid;
   assign ovf    = r_ovf;
   assign busy   = r_busy;

   // s1/s2 resolve metastability; s3 is history for rising-edge detection
   assign w_edge = r_s2 & ~r_s3;
   assign w_term = (r_gate_cnt == GATE_LAST);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (en) w_next = MEASURE;
         // abort takes priority over window completion
         MEASURE: if (!en)        w_next = IDLE;
                  else if (w_term) w_next = LATCH;
         LATCH:   w_next = en ? MEASURE : IDLE;
         default: w_next = IDLE;
      endcase
   end

   // ------------------------------------------------------ input path
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= sig_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   // ------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_gate_cnt <= '0;
         r_edge_cnt <= '0;
         r_sat      <= 1'b0;
         r_count    <= '0;
         r_valid    <= 1'b0;
         r_ovf      <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_busy  <= (w_next == MEASURE);
         case (r_state)
            MEASURE: begin
               if (!en) begin
                  // partial window is discarded; results stay untouched
                  r_gate_cnt <= '0;
                  r_edge_cnt <= '0;
                  r_sat      <= 1'b0;
               end else begin
                  // hold the gate count in the terminal cycle; LATCH clears it
                  if (!w_term) r_gate_cnt <= r_gate_cnt + 1'b1;
                  if (w_edge) begin
                     if (r_edge_cnt == CNT_MAX) r_sat <= 1'b1;
                     else                      r_edge_cnt <= r_edge_cnt + 1'b1;
                  end
               end
            end
            LATCH: begin
               // edges seen during this cycle are intentionally dropped
               r_count    <= r_edge_cnt;
               r_ovf      <= r_sat;
               r_valid    <= 1'b1;
               r_gate_cnt <= '0;
               r_edge_cnt <= '0;
               r_sat      <= 1'b0;
            end
            default: begin
               r_gate_cnt <= '0;
               r_edge_cnt <= '0;
               r_sat      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_freq_meter.sv
// -----------------------------------------------------------------------------
// tb_freq_meter
// Scoreboard bench for freq_meter (GATE=100, W=4). Stimulus pushes the
// expected {count, ovf, cycle-of-valid} for every window it runs; a monitor
// pops and compares whenever valid is seen, and flags missing or stray pulses.
// Cycle index `cyc` equals the number of rising clk edges so far; inputs are
// driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_freq_meter;

   localparam int N    = 8;
   localparam int GATE = 100;
   localparam int W    = 4;

   logic         clk;
   logic         reset;
   logic         en;
   logic         sig_in;
   logic [W-1:0] count;
   logic         valid;
   logic         ovf;
   logic         busy;

   freq_meter #(.N(N), .GATE(GATE), .W(W)) dut (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .sig_in (sig_in),
      .count  (count),
      .valid  (valid),
      .ovf    (ovf),
      .busy   (busy)
   );

   typedef struct {
      int cnt;
      int ovf;
      int cy;
   } exp_t;

   exp_t q[$];
   exp_t m_e;

   int cyc     = 0;
   int n_chk   = 0;
   int n_fail  = 0;
   int gen_per = 0;
   int gen_ph  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   task automatic chk(input string name, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push(input int c, input int o, input int cy);
      exp_t e;
      e.cnt = c;
      e.ovf = o;
      e.cy  = cy;
      q.push_back(e);
   endtask

   task automatic waitc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // run n back-to-back windows starting now (caller is on a falling edge);
   // en drops inside the last LATCH cycle. Returns the first MEASURE cycle.
   task automatic run_win(input int n, output int e0);
      e0 = cyc + 1;
      en = 1'b1;
      waitc(e0 + GATE + (GATE + 1) * (n - 1));
      en = 1'b0;
      waitc(cyc + 5);
   endtask

   // square-wave generator: rise driven at cycles where (cyc-ph)%per == 0
   initial forever begin
      @(negedge clk);
      if (gen_per != 0)
         sig_in = ((((cyc - gen_ph) % gen_per) + gen_per) % gen_per) < (gen_per / 2);
   end

   // monitor / scoreboard
   initial forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cy < cyc) begin
         chk("valid_missing", 0, 1);
         void'(q.pop_front());
      end
      if (valid) begin
         if (q.size() == 0) chk("unexpected_valid", 1, 0);
         else begin
            m_e = q.pop_front();
            chk("valid_cycle", cyc, m_e.cy);
            chk("count", int'(count), m_e.cnt);
            chk("ovf", int'(ovf), m_e.ovf);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      int k;
      reset  = 1'b0;
      en     = 1'b0;
      sig_in = 1'b0;
      @(negedge clk);
      waitc(3);
      chk("rst_count", int'(count), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_ovf",   int'(ovf),   0);
      chk("rst_busy",  int'(busy),  0);
      reset = 1'b1;
      waitc(cyc + 3);

      // steady rate: period 10, edge cycles aligned to e0+5 mod 10 so the
      // LATCH cycles (e0+100, e0+201, e0+302) never coincide with an edge
      k       = cyc + 20;
      gen_per = 10;
      gen_ph  = k + 4;
      waitc(k);
      e0 = k + 1;
      push(10, 0, e0 + 101);
      push(10, 0, e0 + 202);
      push(10, 0, e0 + 303);
      en = 1'b1;
      chk("busy_idle", int'(busy), 0);
      waitc(e0);
      chk("busy_first", int'(busy), 1);
      waitc(e0 + 2 * 101 + 100);
      en = 1'b0;
      waitc(cyc + 5);
      chk("busy_after", int'(busy), 0);

      // DC input held high, then low
      gen_per = 0;
      sig_in  = 1'b1;
      waitc(cyc + 10);
      push(0, 0, cyc + 102);
      run_win(1, e0);
      sig_in = 1'b0;
      waitc(cyc + 10);
      push(0, 0, cyc + 102);
      run_win(1, e0);

      // saturation: 25 edges into a 4-bit counter, then 5 edges
      gen_ph  = 0;
      gen_per = 4;
      waitc(cyc + 20);
      push(15, 1, cyc + 102);
      run_win(1, e0);
      gen_per = 20;
      waitc(cyc + 30);
      push(5, 0, cyc + 102);
      run_win(1, e0);

      // abort at gate_cnt=50
      e0 = cyc + 1;
      en = 1'b1;
      waitc(e0 + 50);
      chk("abort_busy_hi", int'(busy), 1);
      en = 1'b0;
      waitc(e0 + 51);
      chk("abort_busy_lo", int'(busy), 0);
      chk("abort_count",   int'(count), 5);
      chk("abort_ovf",     int'(ovf),   0);
      waitc(cyc + 10);
      push(5, 0, cyc + 102);
      run_win(1, e0);

      // latch count=10, then reset at gate_cnt=70 of the next window
      gen_per = 10;
      waitc(cyc + 20);
      push(10, 0, cyc + 102);
      run_win(1, e0);
      chk("pre_rst_count", int'(count), 10);
      e0 = cyc + 1;
      en = 1'b1;
      waitc(e0 + 70);
      reset = 1'b0;
      #1;
      chk("midrst_count", int'(count), 0);
      chk("midrst_busy",  int'(busy),  0);
      chk("midrst_valid", int'(valid), 0);
      gen_per = 0;
      sig_in  = 1'b0;
      waitc(cyc + 4);
      reset = 1'b1;
      push(0, 0, cyc + 102);
      waitc(cyc + 1 + 100);
      en = 1'b0;
      waitc(cyc + 5);

      // boundary edges: terminal MEASURE cycle counted, LATCH cycle dropped
      waitc(cyc + 10);
      e0 = cyc + 1;
      push(1, 0, e0 + 101);
      push(0, 0, e0 + 202);
      push(0, 0, e0 + 303);
      en = 1'b1;
      waitc(e0 + 97);
      sig_in = 1'b1;
      waitc(e0 + 110);
      sig_in = 1'b0;
      waitc(e0 + 199);
      sig_in = 1'b1;
      waitc(e0 + 210);
      sig_in = 1'b0;
      waitc(e0 + 302);
      en = 1'b0;

      waitc(cyc + 20);
      chk("queue_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
